l1b_buyruk_yanitlayici: RTL and testbench
=========================================

Name: l1b_buyruk_yanitlayici

Overview:
- Instruction-fetch responder between getir1, the instruction memory port and getir2.
- Accepts fetch PCs from getir1, issues word-aligned reads to the memory, and buffers read data in an in-order FIFO.
- Returns that data to getir2 with a valid/ready handshake and pulses the "request issued" strobe that getir2 uses for outstanding-request accounting.
- Never drops or reorders a response: getir2 drains stale responses itself after cek_bosalt.

Parameters:
- PS_BIT, 32, program counter width.
- VERI_BIT, 32, fetch word width.
- DERINLIK, 4, max outstanding requests (issued and not yet popped by getir2); power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- g1_ps_i  in  PS_BIT  fetch PC from getir1.
- g1_ps_gecerli_i  in  1  PC valid.
- g1_ps_kabul_o  out  1  PC accepted into request register this cycle.
- g1_istek_yapildi_o  out  1  one-cycle pulse: a request was issued to memory this cycle.
- bellek_adres_o  out  PS_BIT  memory read address, always word-aligned.
- bellek_istek_gecerli_o  out  1  memory read request valid.
- bellek_istek_hazir_i  in  1  memory accepts request.
- bellek_veri_i  in  VERI_BIT  read data.
- bellek_veri_gecerli_i  in  1  read data valid; no backpressure, responses return in order.
- l1b_buyruk_o  out  VERI_BIT  FIFO head word to getir2.
- l1b_buyruk_gecerli_o  out  1  FIFO non-empty.
- l1b_buyruk_hazir_i  in  1  getir2 pops the head.
- hata_o  out  1  sticky: response arrived with no reserved slot.

Behaviour:
- Reset: all outputs 0; FIFO empty; kredi_r=0; request register empty (state BOS); hata_o cleared. Reset mid-operation discards all in-flight state. Memory responses arriving after reset for pre-reset requests are the system's responsibility, not this block's.
- Request register, 2-state FSM:
  - BOS: g1_ps_kabul_o = g1_ps_gecerli_i. On accept, latch {g1_ps_i[PS_BIT-1:2],2'b00} into istek_adres_r and go to DOLU.
  - DOLU: bellek_istek_gecerli_o = (kredi_r < DERINLIK). Issue handshake = bellek_istek_gecerli_o && bellek_istek_hazir_i.
  - On issue: g1_istek_yapildi_o=1 in the same cycle and kredi_r increments.
  - If g1_ps_gecerli_i is also high in the issue cycle, accept it (g1_ps_kabul_o=1) and stay in DOLU with the new address (back-to-back, one issue per cycle max). Otherwise return to BOS.
  - No issue in DOLU: g1_ps_kabul_o=0, address held stable.
- bellek_adres_o = istek_adres_r. It must not change while bellek_istek_gecerli_o && !bellek_istek_hazir_i.
- Credit: kredi_r = issued − popped, range 0..DERINLIK.
  - Next value = kredi_r + issue − pop, where pop = l1b_buyruk_gecerli_o && l1b_buyruk_hazir_i.
  - Issue gating uses registered kredi_r only: a same-cycle pop does not free a slot until the next cycle.
- FIFO: DERINLIK entries; wrapping read/write pointers with a (log2 DERINLIK)+1-bit count.
  - Push on bellek_veri_gecerli_i; pop as defined above. Simultaneous push and pop at any occupancy is legal: count unchanged.
  - Latency: data pushed in cycle N is visible on l1b_buyruk_o with l1b_buyruk_gecerli_o=1 from cycle N+1. No bypass.
  - l1b_buyruk_o holds the head while not popped; its value when empty is don't-care.
- Error: bellek_veri_gecerli_i with FIFO full and no same-cycle pop sets hata_o (sticky until reset) and drops the word. With correct credit use this is unreachable.
- Pop when empty: ignored (gecerli is 0).
- Wrap-around: pointers wrap modulo DERINLIK; order preserved across the wrap.

Test Plan:
- Single fetch, 2-cycle memory latency: PS=0x0000_0102 accepted at t0.
  - t1: bellek_adres_o=0x0000_0100, issue and g1_istek_yapildi_o pulse.
  - Data 0xDEAD_BEEF returned at t3; l1b_buyruk_gecerli_o=1 at t4; popped at t4; kredi returns to 0.
- Back-to-back streaming: PCs 0x0,0x4,0x8,0xC held valid, memory always ready, getir2 ready = 1.
  - Exactly one issue per cycle; four yapildi pulses; words appear in order.
- Credit stall: DERINLIK=4, getir2 ready = 0, six requests.
  - Exactly 4 issues, then bellek_istek_gecerli_o=0 with the address held.
  - Raise ready: after the first pop, the next issue occurs exactly one cycle later.
- Memory backpressure: bellek_istek_hazir_i=0 for 3 cycles.
  - bellek_adres_o is stable, g1_ps_kabul_o=0, no yapildi pulse until ready rises.
- Simultaneous push/pop at full FIFO plus pointer wrap: 10 sequential words through a depth-4 FIFO.
  - Output sequence is identical to the input sequence; hata_o stays 0.
- Forced error and reset: inject bellek_veri_gecerli_i with FIFO full and no pop.
  - hata_o=1 next cycle.
  - Assert rst_i mid-stream: next cycle all outputs 0, FIFO empty, kredi 0.

Source files
------------

// File: rtl/l1b_buyruk_yanitlayici.sv
// l1b_buyruk_yanitlayici: instruction-fetch responder between getir1, instruction memory and getir2
module l1b_buyruk_yanitlayici #(
  parameter int PS_BIT = 32,
  parameter int VERI_BIT = 32,
  parameter int DERINLIK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PS_BIT-1:0]   g1_ps_i,
  input  logic                g1_ps_gecerli_i,
  output logic                g1_ps_kabul_o,
  output logic                g1_istek_yapildi_o,
  output logic [PS_BIT-1:0]   bellek_adres_o,
  output logic                bellek_istek_gecerli_o,
  input  logic                bellek_istek_hazir_i,
  input  logic [VERI_BIT-1:0] bellek_veri_i,
  input  logic                bellek_veri_gecerli_i,
  output logic [VERI_BIT-1:0] l1b_buyruk_o,
  output logic                l1b_buyruk_gecerli_o,
  input  logic                l1b_buyruk_hazir_i,
  output logic                hata_o
);
  localparam int AW = $clog2(DERINLIK);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DER = CW'(DERINLIK);
  localparam logic BOS = 1'b0;
  localparam logic DOLU = 1'b1;
  logic                durum_r;
  logic [PS_BIT-1:0]   istek_adres_r;
  logic [CW-1:0]       kredi_r;
  logic [CW-1:0]       sayac_r;
  logic [AW-1:0]       yaz_r;
  logic [AW-1:0]       oku_r;
  logic [VERI_BIT-1:0] mem_r [DERINLIK];
  logic                hata_r;
  logic                verilen;
  logic                cek;
  logic                dolu;
  logic                yaz;
  // credit is compared in its registered form so a pop frees a slot only next cycle
  assign bellek_istek_gecerli_o = (durum_r == DOLU) && (kredi_r < DER);
  assign verilen = bellek_istek_gecerli_o && bellek_istek_hazir_i;
  assign g1_ps_kabul_o = g1_ps_gecerli_i && ((durum_r == BOS) || verilen);
  assign g1_istek_yapildi_o = verilen;
  assign bellek_adres_o = istek_adres_r;
  assign l1b_buyruk_gecerli_o = sayac_r != '0;
  assign l1b_buyruk_o = l1b_buyruk_gecerli_o ? mem_r[oku_r] : '0;
  assign cek = l1b_buyruk_gecerli_o && l1b_buyruk_hazir_i;
  assign dolu = sayac_r == DER;
  assign yaz = bellek_veri_gecerli_i && (!dolu || cek);
  assign hata_o = hata_r;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r <= BOS;
      istek_adres_r <= '0;
      kredi_r <= '0;
      sayac_r <= '0;
      yaz_r <= '0;
      oku_r <= '0;
      hata_r <= 1'b0;
    end else begin
      if (g1_ps_kabul_o) istek_adres_r <= g1_ps_i & ~PS_BIT'(3);
      durum_r <= g1_ps_kabul_o ? DOLU : verilen ? BOS : durum_r;
      kredi_r <= kredi_r + CW'(verilen) - CW'(cek);
      sayac_r <= sayac_r + CW'(yaz) - CW'(cek);
      if (yaz) yaz_r <= yaz_r + 1'b1;
      if (cek) oku_r <= oku_r + 1'b1;
      if (bellek_veri_gecerli_i && dolu && !cek) hata_r <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (yaz) mem_r[yaz_r] <= bellek_veri_i;
  end
endmodule

// File: tb/tb_l1b_buyruk_yanitlayici.sv
// tb_l1b_buyruk_yanitlayici: randomized scoreboard bench with a transaction-level fetch model
module tb_l1b_buyruk_yanitlayici;
  localparam int D = 4;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] g1_ps_i;
  logic        g1_ps_gecerli_i;
  logic        g1_ps_kabul_o;
  logic        g1_istek_yapildi_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_istek_gecerli_o;
  logic        bellek_istek_hazir_i;
  logic [31:0] bellek_veri_i;
  logic        bellek_veri_gecerli_i;
  logic [31:0] l1b_buyruk_o;
  logic        l1b_buyruk_gecerli_o;
  logic        l1b_buyruk_hazir_i;
  logic        hata_o;
  l1b_buyruk_yanitlayici #(.PS_BIT(32), .VERI_BIT(32), .DERINLIK(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .g1_ps_i(g1_ps_i), .g1_ps_gecerli_i(g1_ps_gecerli_i),
    .g1_ps_kabul_o(g1_ps_kabul_o), .g1_istek_yapildi_o(g1_istek_yapildi_o),
    .bellek_adres_o(bellek_adres_o), .bellek_istek_gecerli_o(bellek_istek_gecerli_o),
    .bellek_istek_hazir_i(bellek_istek_hazir_i), .bellek_veri_i(bellek_veri_i),
    .bellek_veri_gecerli_i(bellek_veri_gecerli_i), .l1b_buyruk_o(l1b_buyruk_o),
    .l1b_buyruk_gecerli_o(l1b_buyruk_gecerli_o), .l1b_buyruk_hazir_i(l1b_buyruk_hazir_i),
    .hata_o(hata_o));
  always #5 clk_i = ~clk_i;
  typedef struct {int t; logic [31:0] d;} resp_t;
  resp_t       resp_q[$];
  logic [31:0] exp_q[$];
  int          errors = 0, checks = 0;
  int          n = 0, out_m = 0, fcnt = 0, last_t = 0;
  bit          pend = 0, mon_en = 0;
  logic [31:0] pend_addr = '0;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, n);
    end
  endtask
  // monitor: a getir1/getir2 view of the block, outstanding requests and FIFO occupancy as counts
  always @(negedge clk_i) begin
    bit g_exp, iss, acc, pop;
    int t;
    logic [31:0] w;
    #2;
    if (mon_en) begin
      g_exp = pend && (out_m < D);
      iss = g_exp && bellek_istek_hazir_i;
      acc = g1_ps_gecerli_i && (!pend || iss);
      pop = (fcnt > 0) && l1b_buyruk_hazir_i;
      chk("istek_gecerli", {31'b0, bellek_istek_gecerli_o}, {31'b0, g_exp});
      chk("ps_kabul", {31'b0, g1_ps_kabul_o}, {31'b0, acc});
      chk("istek_yapildi", {31'b0, g1_istek_yapildi_o}, {31'b0, iss});
      if (pend) chk("adres", bellek_adres_o, pend_addr);
      chk("buyruk_gecerli", {31'b0, l1b_buyruk_gecerli_o}, {31'b0, fcnt > 0});
      chk("hata", {31'b0, hata_o}, 32'd0);
      if (pop) begin
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk("buyruk", l1b_buyruk_o, w);
      end
      if (iss) begin
        t = n + int'($urandom_range(1, 4));
        if (t <= last_t) t = last_t + 1;
        last_t = t;
        resp_q.push_back('{t, f(bellek_adres_o)});
        out_m++;
      end
      if (acc) begin
        pend_addr = g1_ps_i & ~32'h3;
        exp_q.push_back(f(pend_addr));
        pend = 1;
      end else if (iss) pend = 0;
      if (pop) begin
        out_m--;
        fcnt--;
      end
      if (bellek_veri_gecerli_i) fcnt++;
    end
    n++;
  end
  task automatic drive(input bit v, input logic [31:0] pc, input bit mh, input bit g2);
    resp_t r;
    @(negedge clk_i);
    g1_ps_gecerli_i = v;
    g1_ps_i = pc;
    bellek_istek_hazir_i = mh;
    l1b_buyruk_hazir_i = g2;
    if (resp_q.size() > 0 && resp_q[0].t <= n) begin
      r = resp_q.pop_front();
      bellek_veri_gecerli_i = 1'b1;
      bellek_veri_i = r.d;
    end else begin
      bellek_veri_gecerli_i = 1'b0;
      bellek_veri_i = $urandom;
    end
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_kabul"}, {31'b0, g1_ps_kabul_o}, 32'd0);
    chk({tag, "_yapildi"}, {31'b0, g1_istek_yapildi_o}, 32'd0);
    chk({tag, "_adres"}, bellek_adres_o, 32'd0);
    chk({tag, "_istek_gecerli"}, {31'b0, bellek_istek_gecerli_o}, 32'd0);
    chk({tag, "_buyruk"}, l1b_buyruk_o, 32'd0);
    chk({tag, "_buyruk_gecerli"}, {31'b0, l1b_buyruk_gecerli_o}, 32'd0);
    chk({tag, "_hata"}, {31'b0, hata_o}, 32'd0);
  endtask
  initial begin
    int k;
    rst_i = 1'b1;
    g1_ps_i = '0;
    g1_ps_gecerli_i = 1'b0;
    bellek_istek_hazir_i = 1'b0;
    bellek_veri_i = '0;
    bellek_veri_gecerli_i = 1'b0;
    l1b_buyruk_hazir_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #3 zero_chk("reset");
    rst_i = 1'b0;
    mon_en = 1;
    drive(1, 32'h0000_0102, 1, 1);
    repeat (8) drive(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 1, 1);
    repeat (8) drive(0, 0, 1, 1);
    repeat (14) drive(1, $urandom, 1, 0);
    repeat (12) drive(0, 0, 1, 1);
    drive(1, 32'h0000_2227, 1, 1);
    repeat (3) drive(0, 0, 0, 1);
    repeat (6) drive(0, 0, 1, 1);
    for (int p = 0; p < 8; p++) begin
      int pg1, pmh, pg2;
      pg1 = int'($urandom_range(20, 100));
      pmh = int'($urandom_range(10, 100));
      pg2 = (p == 3) ? 0 : int'($urandom_range(5, 100));
      repeat (300) drive($urandom_range(0, 99) < pg1, $urandom, $urandom_range(0, 99) < pmh,
                         $urandom_range(0, 99) < pg2);
    end
    k = 0;
    while ((pend || out_m != 0 || fcnt != 0 || resp_q.size() != 0) && k < 300) begin
      drive(0, 0, 1, 1);
      k++;
    end
    chk("bosalma_suresi", {31'b0, k >= 300}, 32'd0);
    @(negedge clk_i);
    mon_en = 0;
    l1b_buyruk_hazir_i = 1'b0;
    for (int i = 0; i <= D; i++) begin
      @(negedge clk_i);
      #2 chk("hata_once", {31'b0, hata_o}, 32'd0);
      bellek_veri_gecerli_i = 1'b1;
      bellek_veri_i = 32'h1000 + 32'(i);
    end
    @(negedge clk_i);
    bellek_veri_gecerli_i = 1'b0;
    #2 chk("hata_sonra", {31'b0, hata_o}, 32'd1);
    chk("tam_bas", l1b_buyruk_o, 32'h1000);
    chk("tam_gecerli", {31'b0, l1b_buyruk_gecerli_o}, 32'd1);
    g1_ps_gecerli_i = 1'b1;
    g1_ps_i = 32'h0000_5556;
    bellek_istek_hazir_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    g1_ps_gecerli_i = 1'b0;
    g1_ps_i = '0;
    @(negedge clk_i);
    #2 zero_chk("ara_reset");
    rst_i = 1'b0;
    g1_ps_gecerli_i = 1'b1;
    g1_ps_i = 32'h0000_7ABF;
    @(negedge clk_i);
    g1_ps_gecerli_i = 1'b0;
    #2 chk("reset_sonra_istek", {31'b0, bellek_istek_gecerli_o}, 32'd1);
    chk("reset_sonra_adres", bellek_adres_o, 32'h0000_7ABC);
    chk("reset_sonra_fifo", {31'b0, l1b_buyruk_gecerli_o}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
